// File: rtl/vpi_test_nvmain_if.sv
// Command port between a command-sequencing host and the NVMain-style controller.
// command_enable qualifies arg0..arg4 for one edge; L/C/R/W is accepted only while
// is_issuable is high (otherwise dropped), and a 0x69 poll re-arms is_issuable once space exists.
interface vpi_test_nvmain_if;
  logic        command_enable;
  logic [7:0]  arg0;
  logic [31:0] arg1;
  logic [31:0] arg2;
  logic [31:0] arg3;
  logic [7:0]  arg4;
  logic        is_issuable;
  logic        busy;
  logic [31:0] issued_count;
  logic [31:0] completed_count;
  logic [15:0] dropped_count;

  modport master (
    output command_enable, arg0, arg1, arg2, arg3, arg4,
    input  is_issuable, busy, issued_count, completed_count, dropped_count
  );

  modport slave (
    input  command_enable, arg0, arg1, arg2, arg3, arg4,
    output is_issuable, busy, issued_count, completed_count, dropped_count
  );
endinterface

// File: rtl/vpi_test_nvmain.sv
// NVMain-style command port: ASCII opcode decode, command FIFO with poll-gated
// issue control, and a single service engine with fixed per-type latencies.
module vpi_test_nvmain #(
  parameter int QUEUE_DEPTH = 4,
  parameter int LOAD_LAT    = 4,
  parameter int COMPUTE_LAT = 16,
  parameter int READ_LAT    = 8,
  parameter int WRITE_LAT   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  vpi_test_nvmain_if.slave      bus,
  output logic                  dbg_state,
  output logic [105:0]          dbg_cur
);
  localparam int AW = $clog2(QUEUE_DEPTH);

  typedef enum logic [1:0] {OP_LOAD, OP_COMPUTE, OP_READ, OP_WRITE} op_e;
  typedef struct packed {
    op_e         op;
    logic [31:0] addr;
    logic [31:0] size;
    logic [31:0] count;
    logic [7:0]  mode;
  } entry_t;
  typedef enum logic {S_IDLE, S_SERVICE} state_e;

  state_e        state, state_next;
  entry_t        mem [QUEUE_DEPTH];
  entry_t        head, cur_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ, occ_next;
  logic [31:0]   cnt, head_lat;
  logic [31:0]   issued_q, completed_q;
  logic [15:0]   dropped_q;
  logic          issuable_q;
  logic          cmd_valid, is_query, push, drop, pop, complete, fifo_empty;
  op_e           cmd_op;

  always_comb begin
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    case (bus.arg0)
      8'h4C, 8'h6C: cmd_op = OP_LOAD;
      8'h43, 8'h63: cmd_op = OP_COMPUTE;
      8'h52, 8'h72: cmd_op = OP_READ;
      8'h57, 8'h77: cmd_op = OP_WRITE;
      default:      cmd_valid = 1'b0;
    endcase
  end

  assign is_query   = bus.command_enable && (bus.arg0 == 8'h69);
  assign push       = bus.command_enable && cmd_valid && issuable_q;
  assign drop       = bus.command_enable && cmd_valid && !issuable_q;
  assign fifo_empty = (occ == '0);
  assign head       = mem[rd_ptr];
  assign occ_next   = occ + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: cmd_op, addr: bus.arg1, size: bus.arg2,
                               count: bus.arg3, mode: bus.arg4};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      occ <= occ_next;
    end
  end

  always_comb begin
    case (head.op)
      OP_LOAD:    head_lat = 32'(LOAD_LAT);
      OP_COMPUTE: head_lat = (head.mode == 8'h59) ? 32'(2*COMPUTE_LAT) : 32'(COMPUTE_LAT);
      OP_READ:    head_lat = 32'(READ_LAT);
      default:    head_lat = 32'(WRITE_LAT);
    endcase
  end

  // Engine FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Engine FSM: next state, pop and completion strobes
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    complete   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = S_SERVICE;
        end
      end
      default: begin
        if (cnt == '0) begin
          complete = 1'b1;
          if (!fifo_empty) pop = 1'b1;
          else             state_next = S_IDLE;
        end
      end
    endcase
  end

  // Engine FSM: outputs
  always_comb begin
    bus.busy  = (state == S_SERVICE);
    dbg_state = (state == S_SERVICE);
  end

  // A pop from IDLE happens one edge after acceptance, so it loads one less to
  // keep completion LAT edges after acceptance; chained pops load LAT-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      cur_q <= '0;
    end else if (pop) begin
      cnt   <= (state == S_IDLE) ? head_lat - 32'd2 : head_lat - 32'd1;
      cur_q <= head;
    end else if (state == S_SERVICE && cnt != '0) begin
      cnt <= cnt - 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issuable_q  <= 1'b1;
      issued_q    <= '0;
      completed_q <= '0;
      dropped_q   <= '0;
    end else begin
      if (occ_next == (AW+1)'(QUEUE_DEPTH)) issuable_q <= 1'b0;
      else if (is_query)                    issuable_q <= 1'b1;
      if (push)     issued_q    <= issued_q + 32'd1;
      if (complete) completed_q <= completed_q + 32'd1;
      if (drop && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
    end
  end

  assign bus.is_issuable     = issuable_q;
  assign bus.issued_count    = issued_q;
  assign bus.completed_count = completed_q;
  assign bus.dropped_count   = dropped_q;
  assign dbg_cur             = cur_q;
endmodule

// File: tb/tb_vpi_test_nvmain.sv
// Bench for vpi_test_nvmain: directed scenarios plus random traffic, all checked
// against a timestamp-based reference model (accept, pop and completion edges).
module tb_vpi_test_nvmain;
  localparam int QD          = 4;
  localparam int LOAD_LAT    = 4;
  localparam int COMPUTE_LAT = 16;
  localparam int READ_LAT    = 8;
  localparam int WRITE_LAT   = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         dbg_state;
  logic [105:0] dbg_cur;
  int           checks = 0;
  int           errors = 0;

  vpi_test_nvmain_if bus();

  vpi_test_nvmain #(
    .QUEUE_DEPTH(QD), .LOAD_LAT(LOAD_LAT), .COMPUTE_LAT(COMPUTE_LAT),
    .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state), .dbg_cur(dbg_cur)
  );

  always #5 clk = ~clk;

  // Reference model: every accepted command gets an accept edge, a pop edge and
  // a completion edge; outputs are derived by counting over those timestamps.
  int          t = 0;
  int          last_c = 0;
  int          acc_n = 0;
  int          pop_n = 0;
  bit          m_iss = 1'b1;
  bit          m_busy = 1'b0;
  int unsigned m_issued = 0;
  int unsigned m_completed = 0;
  int unsigned m_dropped = 0;
  int          acc_q[$];
  int          pop_q[$];
  logic [31:0] exp_q[$];

  function automatic int lat_of(input logic [7:0] op, input logic [7:0] mode);
    case (op)
      8'h4C, 8'h6C: return LOAD_LAT;
      8'h43, 8'h63: return (mode == 8'h59) ? 2*COMPUTE_LAT : COMPUTE_LAT;
      8'h52, 8'h72: return READ_LAT;
      8'h57, 8'h77: return WRITE_LAT;
      default:      return 0;
    endcase
  endfunction

  task automatic model_edge(input bit r, input bit cen, input logic [7:0] op, input logic [7:0] mode);
    int lat;
    t++;
    if (r) begin
      last_c = t; acc_n = 0; pop_n = 0; m_iss = 1'b1; m_busy = 1'b0;
      m_issued = 0; m_completed = 0; m_dropped = 0;
      acc_q.delete(); pop_q.delete(); exp_q.delete();
      return;
    end
    foreach (pop_q[i]) if (pop_q[i] == t) pop_n++;
    lat = lat_of(op, mode);
    if (cen && lat != 0) begin
      if (m_iss) begin
        acc_q.push_back(t);
        pop_q.push_back((t + 1 > last_c) ? t + 1 : last_c);
        last_c = ((t > last_c) ? t : last_c) + lat;
        exp_q.push_back(32'(last_c));
        acc_n++;
        m_issued++;
      end else if (m_dropped < 65535) begin
        m_dropped++;
      end
    end
    if (acc_n - pop_n == QD)                 m_iss = 1'b0;
    else if (!m_iss && cen && op == 8'h69)   m_iss = 1'b1;
    m_busy = 1'b0;
    foreach (exp_q[i]) begin
      if (int'(exp_q[i]) == t) m_completed++;
      if (acc_q[i] < t && t < int'(exp_q[i])) m_busy = 1'b1;
    end
  endtask

  task automatic drive(input bit cen, input logic [7:0] op, input logic [31:0] a1,
                       input logic [31:0] a2, input logic [31:0] a3, input logic [7:0] mode);
    bus.command_enable = cen;
    bus.arg0 = op; bus.arg1 = a1; bus.arg2 = a2; bus.arg3 = a3; bus.arg4 = mode;
    @(posedge clk);
    model_edge(rst, cen, op, mode);
    #1;
    bus.command_enable = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 32'd0, 32'd0, 32'd0, 8'h58);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    checks++; if (bus.is_issuable !== 1'b1) begin errors++; $display("FAIL reset_issuable got %0b want 1", bus.is_issuable); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    checks++; if (bus.issued_count !== 32'd0) begin errors++; $display("FAIL reset_issued got %0d want 0", bus.issued_count); end
    checks++; if (bus.completed_count !== 32'd0) begin errors++; $display("FAIL reset_completed got %0d want 0", bus.completed_count); end
    checks++; if (bus.dropped_count !== 16'd0) begin errors++; $display("FAIL reset_dropped got %0d want 0", bus.dropped_count); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state got %0b want 0", dbg_state); end
  endtask

  task automatic test_single_load();
    drive(1'b1, 8'h4C, 32'd0, 32'h10000, 32'd1, 8'h58);
    checks++; if (bus.issued_count !== 32'd1) begin errors++; $display("FAIL load_issued got %0d want 1", bus.issued_count); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL load_busy_accept got %0b want 0", bus.busy); end
    for (int k = 1; k <= LOAD_LAT; k++) begin
      idle();
      // busy holds from the pop edge until the completion edge N+LAT
      checks++; if (bus.busy !== (k < LOAD_LAT)) begin errors++; $display("FAIL load_busy k=%0d got %0b want %0b", k, bus.busy, k < LOAD_LAT); end
      checks++; if (bus.completed_count !== ((k == LOAD_LAT) ? 32'd1 : 32'd0)) begin errors++; $display("FAIL load_completed k=%0d got %0d", k, bus.completed_count); end
      checks++; if (bus.is_issuable !== 1'b1) begin errors++; $display("FAIL load_issuable k=%0d got %0b want 1", k, bus.is_issuable); end
      if (k == 1) begin
        checks++; if (dbg_cur[71:40] !== 32'h10000) begin errors++; $display("FAIL load_dbg_size got %h want 10000", dbg_cur[71:40]); end
      end
    end
  endtask

  task automatic test_fill_and_drop();
    logic [7:0] seq [6];
    seq = '{8'h4C, 8'h43, 8'h4C, 8'h43, 8'h4C, 8'h43};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, seq[i], $urandom, $urandom, $urandom, 8'h58);
      checks++; if (bus.is_issuable !== m_iss) begin errors++; $display("FAIL fill_issuable i=%0d got %0b want %0b", i, bus.is_issuable, m_iss); end
    end
    // the Load ahead of the queue finishes at the 5th push, so the 6th fills it
    checks++; if (bus.is_issuable !== 1'b0) begin errors++; $display("FAIL fill_full got %0b want 0", bus.is_issuable); end
    drive(1'b1, 8'h57, 32'd4, 32'd4, 32'd4, 8'h58);
    checks++; if (bus.dropped_count !== 16'd1) begin errors++; $display("FAIL drop_count got %0d want 1", bus.dropped_count); end
    checks++; if (bus.issued_count !== 32'd7) begin errors++; $display("FAIL drop_issued got %0d want 7", bus.issued_count); end
  endtask

  task automatic test_poll();
    logic [31:0] iss0;
    for (int i = 0; i < 70; i++) begin
      idle();
      checks++; if (bus.is_issuable !== 1'b0) begin errors++; $display("FAIL poll_hold i=%0d got %0b want 0", i, bus.is_issuable); end
      checks++; if (bus.completed_count !== m_completed) begin errors++; $display("FAIL poll_completed i=%0d got %0d want %0d", i, bus.completed_count, m_completed); end
    end
    checks++; if (bus.completed_count !== 32'd7 || bus.busy !== 1'b0) begin errors++; $display("FAIL poll_drained completed %0d busy %0b want 7 0", bus.completed_count, bus.busy); end
    iss0 = bus.issued_count;
    drive(1'b1, 8'h69, 32'd0, 32'd0, 32'd0, 8'h58);
    checks++; if (bus.is_issuable !== 1'b1) begin errors++; $display("FAIL poll_rise got %0b want 1", bus.is_issuable); end
    checks++; if (bus.issued_count !== iss0) begin errors++; $display("FAIL poll_issued got %0d want %0d", bus.issued_count, iss0); end
  endtask

  task automatic test_compute_modes();
    int t0, c1, c2;
    logic [31:0] prev, base;
    c1 = -1; c2 = -1;
    base = bus.completed_count;
    drive(1'b1, 8'h43, 32'd1, 32'd2, 32'd3, 8'h59);
    t0 = t;
    drive(1'b1, 8'h63, 32'd5, 32'd6, 32'd7, 8'h58);
    prev = bus.completed_count;
    for (int i = 0; i < 100 && c2 < 0; i++) begin
      idle();
      if (bus.completed_count != prev) begin
        if (c1 < 0) c1 = t; else c2 = t;
        prev = bus.completed_count;
      end
    end
    checks++; if (c1 - t0 != 2*COMPUTE_LAT) begin errors++; $display("FAIL compute_y_lat got %0d want %0d", c1 - t0, 2*COMPUTE_LAT); end
    checks++; if (c2 - c1 != COMPUTE_LAT) begin errors++; $display("FAIL compute_x_gap got %0d want %0d", c2 - c1, COMPUTE_LAT); end
    checks++; if (bus.completed_count - base !== 32'd2) begin errors++; $display("FAIL compute_count got %0d want 2", bus.completed_count - base); end
  endtask

  task automatic test_case_and_invalid();
    int t0, c1;
    logic [31:0] iss0, cmp0;
    logic [15:0] drp0;
    c1 = -1;
    iss0 = bus.issued_count;
    cmp0 = bus.completed_count;
    drive(1'b1, 8'h72, $urandom, $urandom, $urandom, 8'h58);
    t0 = t;
    checks++; if (bus.issued_count !== iss0 + 32'd1) begin errors++; $display("FAIL lower_r_issued got %0d want %0d", bus.issued_count, iss0 + 32'd1); end
    for (int i = 0; i < 20 && c1 < 0; i++) begin
      idle();
      if (bus.completed_count != cmp0) c1 = t;
    end
    checks++; if (c1 - t0 != READ_LAT) begin errors++; $display("FAIL lower_r_lat got %0d want %0d", c1 - t0, READ_LAT); end
    iss0 = bus.issued_count; cmp0 = bus.completed_count; drp0 = bus.dropped_count;
    drive(1'b1, 8'h61, 32'd9, 32'd9, 32'd9, 8'h58);
    idle();
    checks++; if (bus.issued_count !== iss0 || bus.completed_count !== cmp0 || bus.dropped_count !== drp0) begin
      errors++; $display("FAIL invalid_op counters got %0d/%0d/%0d want %0d/%0d/%0d",
        bus.issued_count, bus.completed_count, bus.dropped_count, iss0, cmp0, drp0);
    end
    checks++; if (bus.busy !== 1'b0 || bus.is_issuable !== 1'b1) begin errors++; $display("FAIL invalid_op status busy %0b iss %0b want 0 1", bus.busy, bus.is_issuable); end
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h57, $urandom, $urandom, $urandom, 8'h58);
    checks++; if (bus.busy !== 1'b1 || dbg_state !== 1'b1) begin errors++; $display("FAIL midop_busy got %0b/%0b want 1", bus.busy, dbg_state); end
    rst = 1'b1;
    idle();
    rst = 1'b0;
    checks++; if (bus.issued_count !== 32'd0 || bus.completed_count !== 32'd0 || bus.dropped_count !== 16'd0) begin
      errors++; $display("FAIL midop_counters got %0d/%0d/%0d want 0", bus.issued_count, bus.completed_count, bus.dropped_count);
    end
    checks++; if (bus.busy !== 1'b0 || bus.is_issuable !== 1'b1) begin errors++; $display("FAIL midop_status busy %0b iss %0b want 0 1", bus.busy, bus.is_issuable); end
    for (int i = 0; i < 40; i++) begin
      idle();
      checks++; if (bus.completed_count !== 32'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL midop_quiet i=%0d completed %0d busy %0b", i, bus.completed_count, bus.busy); end
    end
  endtask

  task automatic test_random();
    logic [7:0] ops [10];
    ops = '{8'h4C, 8'h6C, 8'h43, 8'h63, 8'h52, 8'h72, 8'h57, 8'h77, 8'h69, 8'h61};
    for (int i = 0; i < 500; i++) begin
      logic [7:0] op, mode;
      bit cen;
      cen  = ($urandom_range(0, 3) != 0);
      op   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : ops[$urandom_range(0, 9)];
      mode = ($urandom_range(0, 2) == 0) ? 8'h59 : (($urandom_range(0, 1) == 1) ? 8'h58 : 8'($urandom));
      drive(cen, op, $urandom, $urandom, $urandom, mode);
      checks++; if (bus.is_issuable !== m_iss) begin errors++; $display("FAIL rnd_issuable i=%0d got %0b want %0b", i, bus.is_issuable, m_iss); end
      checks++; if (bus.busy !== m_busy || dbg_state !== m_busy) begin errors++; $display("FAIL rnd_busy i=%0d got %0b/%0b want %0b", i, bus.busy, dbg_state, m_busy); end
      checks++; if (bus.issued_count !== m_issued) begin errors++; $display("FAIL rnd_issued i=%0d got %0d want %0d", i, bus.issued_count, m_issued); end
      checks++; if (bus.completed_count !== m_completed) begin errors++; $display("FAIL rnd_completed i=%0d got %0d want %0d", i, bus.completed_count, m_completed); end
      checks++; if (bus.dropped_count !== 16'(m_dropped)) begin errors++; $display("FAIL rnd_dropped i=%0d got %0d want %0d", i, bus.dropped_count, m_dropped); end
    end
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.command_enable = 1'b0;
    bus.arg0 = 8'h00; bus.arg1 = 32'd0; bus.arg2 = 32'd0; bus.arg3 = 32'd0; bus.arg4 = 8'h58;
    test_reset();
    test_single_load();
    test_fill_and_drop();
    test_poll();
    test_compute_modes();
    test_case_and_invalid();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
